// File: rtl/pipe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : pipe_rr_scheduler
// Description : Round-robin scheduler that lets N_REQ AXI-stream requesters
//               share one fixed-latency register-slice pipeline. A {valid,id}
//               tag travels beside the data so every output beat can be
//               attributed to its source. Issue is gated by credits from the
//               downstream buffer, because the pipeline has no backpressure.
// Ports       : aclk, areset      - clock, synchronous active-high reset
//               s_tvalid/s_tready - per-requester handshake (ready one-hot/0)
//               s_tdata           - packed requester data, slice i = req i
//               p_tdata, p_issue  - pipeline input data and issue strobe
//               m_tvalid, m_tid   - tag at the pipeline output
//               credit_return     - downstream freed one entry
//               credits           - current credit count
//               cred_err          - sticky credit overflow flag
//               idle              - all credits home and no tag in flight
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_rr_scheduler #(
  parameter int N_REQ     = 4,
  parameter int N_STAGES  = 1,
  parameter int CREDITS   = 8,
  parameter int DATA_BITS = 32,
  parameter int ID_BITS   = $clog2(N_REQ),
  parameter int CNT_BITS  = $clog2(CREDITS + 1)
) (
  input  logic                       aclk,
  input  logic                       areset,
  input  logic [N_REQ-1:0]           s_tvalid,
  output logic [N_REQ-1:0]           s_tready,
  input  logic [N_REQ*DATA_BITS-1:0] s_tdata,
  output logic [DATA_BITS-1:0]       p_tdata,
  output logic                       p_issue,
  output logic                       m_tvalid,
  output logic [ID_BITS-1:0]         m_tid,
  input  logic                       credit_return,
  output logic [CNT_BITS-1:0]        credits,
  output logic                       cred_err,
  output logic                       idle
);

  localparam logic [CNT_BITS-1:0] CRED_MAX = CNT_BITS'(CREDITS);
  localparam logic [ID_BITS-1:0]  LAST_ID  = ID_BITS'(N_REQ - 1);

  logic [ID_BITS-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CNT_BITS-1:0] cnt_q, cnt_d;
  logic                err_q, err_d;
  logic [N_STAGES-1:0] tag_vld_q;
  logic [ID_BITS-1:0]  tag_id_q [N_STAGES];

  logic                found_w;
  logic [ID_BITS-1:0]  gnt_w;
  logic [ID_BITS-1:0]  idx_w;

  // Rotating priority search: start at rr_ptr and wrap modulo N_REQ.
  always_comb begin
    found_w = 1'b0;
    gnt_w   = '0;
    idx_w   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx_w = ID_BITS'((int'(rr_ptr_q) + k) % N_REQ);
      if (!found_w && s_tvalid[idx_w]) begin
        found_w = 1'b1;
        gnt_w   = idx_w;
      end
    end
  end

  always_comb begin
    s_tready = '0;
    if (found_w && (cnt_q != '0) && !areset) begin
      s_tready = N_REQ'(1) << gnt_w;
    end
  end

  assign p_issue = |(s_tvalid & s_tready);
  assign p_tdata = found_w ? s_tdata[int'(gnt_w)*DATA_BITS +: DATA_BITS] : '0;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (p_issue) begin
      rr_ptr_d = (gnt_w == LAST_ID) ? '0 : gnt_w + 1'b1;
    end
  end

  // Simultaneous issue and return cancel out. A return with every credit
  // already home means the downstream buffer miscounted: flag it and hold.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    if (p_issue && !credit_return) begin
      cnt_d = cnt_q - 1'b1;
    end else if (!p_issue && credit_return) begin
      if (cnt_q == CRED_MAX) begin
        err_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      rr_ptr_q <= '0;
      cnt_q    <= CRED_MAX;
      err_q    <= 1'b0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
    end
  end

  // Tag shift register mirrors the data pipeline stage-for-stage. The id is
  // zeroed for empty slots so m_tid reads 0 whenever m_tvalid is low.
  always_ff @(posedge aclk) begin
    if (areset) begin
      tag_vld_q <= '0;
      for (int s = 0; s < N_STAGES; s++) begin
        tag_id_q[s] <= '0;
      end
    end else begin
      tag_vld_q[0] <= p_issue;
      tag_id_q[0]  <= p_issue ? gnt_w : '0;
      for (int s = 1; s < N_STAGES; s++) begin
        tag_vld_q[s] <= tag_vld_q[s-1];
        tag_id_q[s]  <= tag_id_q[s-1];
      end
    end
  end

  assign m_tvalid = !areset && tag_vld_q[N_STAGES-1];
  assign m_tid    = m_tvalid ? tag_id_q[N_STAGES-1] : '0;
  assign credits  = cnt_q;
  assign cred_err = err_q;
  assign idle     = (cnt_q == CRED_MAX) && !(|tag_vld_q);

endmodule
`default_nettype wire

// File: tb/tb_pipe_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_rr_scheduler
// Description : Self-checking bench. Instance A: N_STAGES=3, CREDITS=8.
//               Instance B: N_STAGES=1, CREDITS=2 (credit exhaustion).
//               Expected tags of A are queued at issue and popped at output.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_rr_scheduler;

  logic clk;
  int   cyc;
  int   checks;
  int   errors;

  // Instance A
  logic         a_rst;
  logic [3:0]   a_valid;
  logic [3:0]   a_ready;
  logic [127:0] a_data;
  logic [31:0]  a_pdata;
  logic         a_issue;
  logic         a_mtv;
  logic [1:0]   a_mtid;
  logic         a_ret;
  logic [3:0]   a_cred;
  logic         a_err;
  logic         a_idle;

  // Instance B
  logic         b_rst;
  logic [3:0]   b_valid;
  logic [3:0]   b_ready;
  logic [127:0] b_data;
  logic [31:0]  b_pdata;
  logic         b_issue;
  logic         b_mtv;
  logic [1:0]   b_mtid;
  logic         b_ret;
  logic [1:0]   b_cred;
  logic         b_err;
  logic         b_idle;

  typedef struct {
    logic [1:0] id;
    int         due;
  } exp_t;

  exp_t sb_q[$];
  int   exp_ptr;

  pipe_rr_scheduler #(.N_REQ(4), .N_STAGES(3), .CREDITS(8), .DATA_BITS(32)) u_dut_a (
    .aclk(clk), .areset(a_rst), .s_tvalid(a_valid), .s_tready(a_ready),
    .s_tdata(a_data), .p_tdata(a_pdata), .p_issue(a_issue), .m_tvalid(a_mtv),
    .m_tid(a_mtid), .credit_return(a_ret), .credits(a_cred), .cred_err(a_err),
    .idle(a_idle)
  );

  pipe_rr_scheduler #(.N_REQ(4), .N_STAGES(1), .CREDITS(2), .DATA_BITS(32)) u_dut_b (
    .aclk(clk), .areset(b_rst), .s_tvalid(b_valid), .s_tready(b_ready),
    .s_tdata(b_data), .p_tdata(b_pdata), .p_issue(b_issue), .m_tvalid(b_mtv),
    .m_tid(b_mtid), .credit_return(b_ret), .credits(b_cred), .cred_err(b_err),
    .idle(b_idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor for instance A: pops the scoreboard on every tagged beat.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!a_rst) begin
        if (a_mtv) begin
          checks++;
          if (sb_q.size() == 0) begin
            errors++;
            $display("FAIL tag_unexpected: m_tid=%0d at cycle %0d, none expected", a_mtid, cyc);
          end else begin
            e = sb_q.pop_front();
            if (a_mtid !== e.id || cyc != e.due) begin
              errors++;
              $display("FAIL tag_out: id=%0d cycle=%0d expected id=%0d cycle=%0d",
                       a_mtid, cyc, e.id, e.due);
            end
          end
        end else begin
          checks++;
          if (a_mtid !== 2'd0) begin
            errors++;
            $display("FAIL tid_idle: m_tid=%0d expected 0 while m_tvalid=0", a_mtid);
          end
          if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
            e = sb_q.pop_front();
            errors++;
            $display("FAIL tag_missing: no beat at cycle %0d, expected id=%0d", cyc, e.id);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Bounded wait until every queued beat of A has come out.
  task automatic wait_drain();
    int n;
    n = 0;
    while (sb_q.size() > 0 && n < 20) begin
      next_cycle();
      n++;
    end
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d beats outstanding, expected 0", sb_q.size());
      sb_q.delete();
    end
    next_cycle();
  endtask

  task automatic test_reset();
    a_valid = 4'hF;
    b_valid = 4'hF;
    @(negedge clk);
    checks++;
    if (a_ready !== 4'h0 || a_issue !== 1'b0 || b_ready !== 4'h0) begin
      errors++;
      $display("FAIL reset_ready: a_ready=%h a_issue=%b b_ready=%h expected 0/0/0",
               a_ready, a_issue, b_ready);
    end
    checks++;
    if (a_mtv !== 1'b0 || a_mtid !== 2'd0 || a_cred !== 4'd8 || a_err !== 1'b0 || a_idle !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: mtv=%b mtid=%0d cred=%0d err=%b idle=%b expected 0/0/8/0/1",
               a_mtv, a_mtid, a_cred, a_err, a_idle);
    end
    next_cycle();
    a_valid = 4'h0;
    b_valid = 4'h0;
    a_rst   = 1'b0;
    b_rst   = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic test_single();
    a_data[2*32 +: 32] = 32'h0000_00A5;
    a_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (a_issue !== 1'b1 || a_ready !== 4'b0100 || a_pdata !== 32'hA5) begin
      errors++;
      $display("FAIL single_issue: issue=%b ready=%h pdata=%h expected 1/4/a5",
               a_issue, a_ready, a_pdata);
    end
    sb_q.push_back('{id: 2'd2, due: cyc + 3});
    exp_ptr = 3;
    next_cycle();
    a_valid = 4'h0;
    @(negedge clk);
    checks++;
    if (a_cred !== 4'd7 || a_issue !== 1'b0) begin
      errors++;
      $display("FAIL single_credit: cred=%0d issue=%b expected 7/0", a_cred, a_issue);
    end
    next_cycle();
    a_ret = 1'b1;
    next_cycle();
    a_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cred !== 4'd8) begin
      errors++;
      $display("FAIL single_return: cred=%0d expected 8", a_cred);
    end
    wait_drain();
  endtask

  task automatic test_rr();
    for (int i = 0; i < 4; i++) a_data[i*32 +: 32] = 32'hC0DE_0000 + i;
    a_valid = 4'hF;
    a_ret   = 1'b1;
    for (int n = 0; n < 8; n++) begin
      logic [3:0]  er;
      logic [31:0] ed;
      @(negedge clk);
      er = 4'b0001 << exp_ptr;
      ed = 32'hC0DE_0000 + exp_ptr;
      checks++;
      if (a_ready !== er || a_issue !== 1'b1 || a_pdata !== ed || a_cred !== 4'd8) begin
        errors++;
        $display("FAIL rr_grant: n=%0d ready=%h issue=%b pdata=%h cred=%0d expected %h/1/%h/8",
                 n, a_ready, a_issue, a_pdata, a_cred, er, ed);
      end
      sb_q.push_back('{id: 2'(exp_ptr), due: cyc + 3});
      exp_ptr = (exp_ptr + 1) % 4;
      next_cycle();
    end
    a_valid = 4'h0;
    a_ret   = 1'b0;
    wait_drain();
  endtask

  task automatic test_same_cycle();
    logic [3:0] er;
    a_valid = 4'hF;
    a_ret   = 1'b0;
    for (int n = 0; n < 9; n++) begin
      a_ret = (n == 7);
      @(negedge clk);
      er = 4'b0001 << exp_ptr;
      checks++;
      if (a_ready !== er || a_issue !== 1'b1 || a_cred !== 4'(n < 8 ? 8 - n : 1)) begin
        errors++;
        $display("FAIL drain_issue: n=%0d ready=%h issue=%b cred=%0d expected %h/1/%0d",
                 n, a_ready, a_issue, a_cred, er, (n < 8 ? 8 - n : 1));
      end
      sb_q.push_back('{id: 2'(exp_ptr), due: cyc + 3});
      exp_ptr = (exp_ptr + 1) % 4;
      next_cycle();
    end
    a_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cred !== 4'd0 || a_ready !== 4'h0 || a_issue !== 1'b0 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_empty: cred=%0d ready=%h issue=%b err=%b expected 0/0/0/0",
               a_cred, a_ready, a_issue, a_err);
    end
    next_cycle();
    a_valid = 4'h0;
    a_ret   = 1'b1;
    repeat (8) next_cycle();
    a_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (a_cred !== 4'd8 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL same_cycle_refill: cred=%0d err=%b expected 8/0", a_cred, a_err);
    end
    wait_drain();
  endtask

  task automatic test_cred_err();
    @(negedge clk);
    checks++;
    if (a_idle !== 1'b1 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL pre_err_idle: idle=%b err=%b expected 1/0", a_idle, a_err);
    end
    next_cycle();
    a_ret = 1'b1;
    next_cycle();
    a_ret = 1'b0;
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1 || a_cred !== 4'd8 || a_idle !== 1'b1) begin
      errors++;
      $display("FAIL cred_err_set: err=%b cred=%0d idle=%b expected 1/8/1", a_err, a_cred, a_idle);
    end
    repeat (3) next_cycle();
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1) begin
      errors++;
      $display("FAIL cred_err_sticky: err=%b expected 1", a_err);
    end
    next_cycle();
  endtask

  task automatic test_credit_limit();
    logic [3:0] exp_rdy [8];
    exp_rdy = '{4'b0001, 4'b0010, 4'h0, 4'h0, 4'h0, 4'h0, 4'b0100, 4'h0};
    for (int i = 0; i < 4; i++) b_data[i*32 +: 32] = 32'hB000_0000 + i;
    b_valid = 4'hF;
    for (int k = 0; k < 8; k++) begin
      b_ret = (k == 5);
      @(negedge clk);
      checks++;
      if (b_ready !== exp_rdy[k] || b_issue !== (exp_rdy[k] != 4'h0)) begin
        errors++;
        $display("FAIL credit_limit: k=%0d ready=%h issue=%b expected %h", k, b_ready, b_issue, exp_rdy[k]);
      end
      if (k == 1) begin
        checks++;
        if (b_mtv !== 1'b1 || b_mtid !== 2'd0) begin
          errors++;
          $display("FAIL b_tag: mtv=%b mtid=%0d expected 1/0", b_mtv, b_mtid);
        end
      end
      if (k == 2) begin
        checks++;
        if (b_cred !== 2'd0) begin
          errors++;
          $display("FAIL b_credits_empty: cred=%0d expected 0", b_cred);
        end
      end
      next_cycle();
    end
    b_valid = 4'h0;
    b_ret   = 1'b0;
  endtask

  task automatic test_reset_midstream();
    logic [3:0] er;
    a_valid = 4'hF;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      er = 4'b0001 << exp_ptr;
      checks++;
      if (a_ready !== er || a_issue !== 1'b1) begin
        errors++;
        $display("FAIL mid_issue: n=%0d ready=%h issue=%b expected %h/1", n, a_ready, a_issue, er);
      end
      sb_q.push_back('{id: 2'(exp_ptr), due: cyc + 3});
      exp_ptr = (exp_ptr + 1) % 4;
      next_cycle();
    end
    a_rst = 1'b1;
    sb_q.delete();
    @(negedge clk);
    checks++;
    if (a_ready !== 4'h0 || a_issue !== 1'b0 || a_mtv !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_gate: ready=%h issue=%b mtv=%b expected 0/0/0", a_ready, a_issue, a_mtv);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (a_mtv !== 1'b0 || a_cred !== 4'd8 || a_idle !== 1'b1 || a_err !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_state: mtv=%b cred=%0d idle=%b err=%b expected 0/8/1/0",
               a_mtv, a_cred, a_idle, a_err);
    end
    next_cycle();
    a_rst   = 1'b0;
    a_valid = 4'b1010;
    exp_ptr = 0;
    @(negedge clk);
    checks++;
    if (a_ready !== 4'b0010 || a_issue !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_grant: ready=%h issue=%b expected 2/1", a_ready, a_issue);
    end
    sb_q.push_back('{id: 2'd1, due: cyc + 3});
    next_cycle();
    a_valid = 4'h0;
    wait_drain();
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    exp_ptr = 0;
    a_rst   = 1'b1;
    b_rst   = 1'b1;
    a_valid = '0;
    b_valid = '0;
    a_data  = '0;
    b_data  = '0;
    a_ret   = 1'b0;
    b_ret   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_rr();
    test_same_cycle();
    test_cred_err();
    test_credit_limit();
    test_reset_midstream();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
